// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory master.
//   - RISC-V funct3 encodings for LB/LH/LW/LBU/LHU and SB/SH/SW
//   - FSM state type
//   - access_err(): request legality check done at acceptance
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Returns 1 when a request must be answered with an error instead of a
  // memory access: unsupported funct3, misaligned halfword/word, or an
  // address with any bit set at or above mem_addr_bits.
  function automatic logic access_err(input logic        store,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input int unsigned mem_addr_bits);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    if (store) begin
      bad_f3 = (funct3 > F3_W);
    end else begin
      bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    // funct3[1:0] encodes access size for every legal code: 0=byte,1=half,2=word
    misaligned   = ((funct3[1:0] == 2'd1) && addr[0]) ||
                   ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    out_of_range = ((addr >> mem_addr_bits) != 32'd0);
    return bad_f3 || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   word     : word read from memory (source for load extract and store merge)
//   wdata    : right-aligned store data
//   addr_lo  : byte offset within the word
//   funct3   : access size / signedness
//   rdata    : extracted and sign/zero-extended load result (0 for bad funct3)
//   merged   : word with the addressed byte/halfword lane replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'd0, byte_sel};
      F3_HU:   rdata = {16'd0, half_sel};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the core MEM stage and a word-addressed RAM.
// Converts byte/halfword/word loads and stores into whole-word accesses;
// sub-word stores are done as read-modify-write.
//   clk, reset         : clock (rising edge), async active-high reset
//   req_*              : valid/ready request channel (store flag, funct3,
//                        byte address, right-aligned store data)
//   resp_*             : valid/ready response channel (extended load data,
//                        error flag)
//   mem_addr/mem_wdata : word-aligned address and write word to the RAM
//   mem_wr_en/rd_en    : one-cycle write/read strobes, never both high
//   mem_rdata          : combinational read data from the RAM
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_ready = (state == IDLE) && !reset;
  assign req_err   = access_err(req_store, req_funct3, req_addr, MEM_ADDR_BITS);

  lsu_lane_align u_lane_align (
    .word    (mem_rdata),
    .wdata   (wdata_q),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .rdata   (load_data),
    .merged  (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_store && (req_funct3 == F3_W)) begin
                mem_wdata <= req_wdata;
                mem_wr_en <= 1'b1;
                state     <= WRITE;
              end else begin
                // loads and sub-word stores both start with a word read
                mem_rd_en <= 1'b1;
                state     <= READ;
              end
            end
          end
        end

        READ: begin
          mem_rd_en <= 1'b0;
          if (store_q) begin
            mem_wdata <= merged_word;
            mem_wr_en <= 1'b1;
            state     <= WRITE;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        WRITE: begin
          mem_wr_en  <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
